// File: rtl/bus_tx_fifo_if.sv
// Host/bus-side signal bundle of the per-device transmit FIFO.
// The FIFO connects through the slave modport and its user through the master modport.
interface bus_tx_fifo_if #(
  parameter int pckg_sz   = 16,
  parameter int depth     = 16,
  parameter int ovf_cnt_w = 8
);
  localparam int CNT_W = $clog2(depth + 1);

  logic                 push;
  logic [pckg_sz-1:0]   D_push;
  logic                 pop;
  logic                 full;
  logic                 almost_full;
  logic                 pndng;
  logic [pckg_sz-1:0]   D_pop;
  logic [CNT_W-1:0]     count;
  logic                 overflow;
  logic [ovf_cnt_w-1:0] ovf_cnt;

  modport master (
    output push, D_push, pop,
    input  full, almost_full, pndng, D_pop, count, overflow, ovf_cnt
  );

  modport slave (
    input  push, D_push, pop,
    output full, almost_full, pndng, D_pop, count, overflow, ovf_cnt
  );
endinterface

// File: rtl/bus_tx_fifo.sv
// Per-device first-word-fall-through transmit FIFO feeding the bus arbiter.
// The head entry is held in its own register so D_pop never depends
// combinationally on push/pop. Dropped pushes are counted (saturating).
module bus_tx_fifo #(
  parameter int pckg_sz         = 16,
  parameter int depth           = 16,
  parameter int almost_full_lvl = 14,
  parameter int ovf_cnt_w       = 8
) (
  input logic          clk,
  input logic          reset,
  bus_tx_fifo_if.slave bus
);
  localparam int CNT_W = $clog2(depth + 1);
  localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;

  localparam logic [CNT_W-1:0]     DEPTH_C    = CNT_W'(depth);
  localparam logic [CNT_W-1:0]     AF_LVL_C   = CNT_W'(almost_full_lvl);
  localparam logic [CNT_W-1:0]     ONE_C      = CNT_W'(1);
  localparam logic [PTR_W-1:0]     PTR_LAST_C = PTR_W'(depth - 1);
  localparam logic [ovf_cnt_w-1:0] OVF_MAX_C  = '1;

  // Pointer advance with explicit wrap so depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == PTR_LAST_C) begin
      r = '0;
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

  logic [pckg_sz-1:0]   mem_q [depth];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [pckg_sz-1:0]   head_q, head_d;
  logic                 ovf_q, ovf_d;
  logic [ovf_cnt_w-1:0] ovf_cnt_q, ovf_cnt_d;
  logic                 pop_valid_s;
  logic                 push_acc_s;
  logic                 drop_s;

  // Next-state computation: accept/drop decisions, pointers, occupancy and next head.
  always_comb begin
    pop_valid_s = bus.pop && (count_q != '0);
    push_acc_s  = bus.push && ((count_q != DEPTH_C) || pop_valid_s);
    drop_s      = bus.push && !push_acc_s;

    if (push_acc_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_valid_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_acc_s, pop_valid_s})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    // The head register mirrors mem[rd_ptr] except when the entry arriving
    // this cycle becomes the head directly (empty FIFO, or last entry popped).
    if (count_d == '0) begin
      head_d = '0;
    end else if (count_q == '0) begin
      head_d = bus.D_push;
    end else if (pop_valid_s) begin
      if (count_q == ONE_C) begin
        head_d = bus.D_push;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end else begin
      head_d = head_q;
    end

    ovf_d = drop_s;
    if (drop_s && (ovf_cnt_q != OVF_MAX_C)) begin
      ovf_cnt_d = ovf_cnt_q + ovf_cnt_w'(1);
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  // Control state: synchronous reset discards in-flight data and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      head_q    <= '0;
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      head_q    <= head_d;
      ovf_q     <= ovf_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Storage write on accepted push; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (!reset && push_acc_s) begin
      mem_q[wr_ptr_q] <= bus.D_push;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign bus.count       = count_q;
  assign bus.full        = (count_q == DEPTH_C);
  assign bus.almost_full = (count_q >= AF_LVL_C);
  assign bus.pndng       = (count_q != '0);
  assign bus.D_pop       = head_q;
  assign bus.overflow    = ovf_q;
  assign bus.ovf_cnt     = ovf_cnt_q;
endmodule
